// File: rtl/filter2d_pkg.sv
// Shared filter2d definitions: default frame geometry and the raster source state encoding.
package filter2d_pkg;

  localparam int FRAME_H    = 480;
  localparam int FRAME_W    = 640;
  localparam int DIN_WIDTH  = 8;
  localparam int SRC_HBLANK = 4;
  localparam int SRC_VBLANK = 16;

  typedef enum logic [2:0] {
    SRC_IDLE,
    SRC_SOF,
    SRC_ACTIVE,
    SRC_HBLK,
    SRC_VBLK
  } src_state_t;

endpackage

// File: rtl/filter2d_raster_cnt.sv
// Column/row position and blanking counters for the filter2d raster source.
module filter2d_raster_cnt #(
  parameter int FRAME_H = 480,
  parameter int FRAME_W = 640,
  parameter int HBLANK  = 4,
  parameter int VBLANK  = 16
) (
  input  logic clock,
  input  logic rst,
  input  logic adv,
  input  logic blank_en,
  input  logic blank_sel,
  output logic last_col,
  output logic last_row,
  output logic blank_done
);

  localparam int COL_W     = $clog2(FRAME_W) + 1;
  localparam int ROW_W     = $clog2(FRAME_H) + 1;
  localparam int BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BLANK_W   = $clog2(BLANK_MAX) + 1;
  // Terminal counts; a zero-length blank never enters its state, so 0 is a safe stand-in.
  localparam int HLIM      = (HBLANK > 0) ? HBLANK - 1 : 0;
  localparam int VLIM      = (VBLANK > 0) ? VBLANK - 1 : 0;

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [BLANK_W-1:0] blank_cnt;
  logic [BLANK_W-1:0] blank_lim;

  assign last_col   = (col == COL_W'(FRAME_W - 1));
  assign last_row   = (row == ROW_W'(FRAME_H - 1));
  assign blank_lim  = blank_sel ? BLANK_W'(VLIM) : BLANK_W'(HLIM);
  assign blank_done = blank_en && (blank_cnt == blank_lim);

  always_ff @(posedge clock) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst || !blank_en || blank_done) begin
      blank_cnt <= '0;
    end else begin
      blank_cnt <= blank_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/filter2d_frame_src.sv
// Raster frame transmitter feeding filter2d from a valid/ready pixel source.
// Optional FILTER2D_SRC_PATTERN_EN adds pattern_sel: internal (row+col) test pattern.
module filter2d_frame_src #(
  parameter int FRAME_H    = filter2d_pkg::FRAME_H,
  parameter int FRAME_W    = filter2d_pkg::FRAME_W,
  parameter int DATA_WIDTH = filter2d_pkg::DIN_WIDTH,
  parameter int HBLANK     = filter2d_pkg::SRC_HBLANK,
  parameter int VBLANK     = filter2d_pkg::SRC_VBLANK
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  input  logic                  pix_vld,
  output logic                  pix_rdy,
  input  logic [DATA_WIDTH-1:0] pix,
`ifdef FILTER2D_SRC_PATTERN_EN
  input  logic                  pattern_sel,
`endif
  output logic                  frame_start,
  output logic                  dout_vld,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  frame_done,
  output logic                  stall
);

  import filter2d_pkg::*;

  src_state_t state, state_nxt;
  logic xfer, blank_en, frame_end;
  logic last_col, last_row, blank_done;
  logic gen_mode;
  logic [DATA_WIDTH-1:0] pix_src;

  filter2d_raster_cnt #(
    .FRAME_H (FRAME_H),
    .FRAME_W (FRAME_W),
    .HBLANK  (HBLANK),
    .VBLANK  (VBLANK)
  ) u_cnt (
    .clock      (clock),
    .rst        (rst),
    .adv        (xfer),
    .blank_en   (blank_en),
    .blank_sel  (state == SRC_VBLK),
    .last_col   (last_col),
    .last_row   (last_row),
    .blank_done (blank_done)
  );

`ifdef FILTER2D_SRC_PATTERN_EN
  logic                  pat_q;
  logic [DATA_WIDTH-1:0] pat_val, pat_row;

  always_ff @(posedge clock) begin
    if (rst) begin
      pat_q <= 1'b0;
    end else if (state == SRC_IDLE && start) begin
      pat_q <= pattern_sel;
    end
  end

  // pat_row tracks the value at col 0 of the current line, so pat_val == row + col.
  always_ff @(posedge clock) begin
    if (state == SRC_SOF) begin
      pat_val <= '0;
      pat_row <= '0;
    end else if (xfer) begin
      if (last_col) begin
        pat_val <= pat_row + 1'b1;
        pat_row <= pat_row + 1'b1;
      end else begin
        pat_val <= pat_val + 1'b1;
      end
    end
  end

  assign gen_mode = pat_q;
  assign pix_src  = pat_q ? pat_val : pix;
`else
  assign gen_mode = 1'b0;
  assign pix_src  = pix;
`endif

  assign pix_rdy = (state == SRC_ACTIVE) && !gen_mode;

  always_ff @(posedge clock) begin
    if (rst) state <= SRC_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    blank_en  = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      SRC_IDLE:   if (start) state_nxt = SRC_SOF;
      SRC_SOF:    state_nxt = SRC_ACTIVE;
      SRC_ACTIVE: begin
        xfer = gen_mode || pix_vld;
        if (xfer && last_col) begin
          if (!last_row) begin
            state_nxt = (HBLANK == 0) ? SRC_ACTIVE : SRC_HBLK;
          end else if (VBLANK == 0) begin
            state_nxt = SRC_IDLE;
            frame_end = 1'b1;
          end else begin
            state_nxt = SRC_VBLK;
          end
        end
      end
      SRC_HBLK: begin
        blank_en = 1'b1;
        if (blank_done) state_nxt = SRC_ACTIVE;
      end
      SRC_VBLK: begin
        blank_en = 1'b1;
        if (blank_done) begin
          state_nxt = SRC_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = SRC_IDLE;
    endcase
  end

  // Output register stage: one cycle behind the state/transfer decision.
  always_ff @(posedge clock) begin
    if (rst) begin
      busy        <= 1'b0;
      frame_start <= 1'b0;
      dout_vld    <= 1'b0;
      frame_done  <= 1'b0;
      stall       <= 1'b0;
      dout        <= '0;
    end else begin
      busy        <= (state_nxt != SRC_IDLE);
      frame_start <= (state == SRC_IDLE) && (state_nxt == SRC_SOF);
      dout_vld    <= xfer;
      frame_done  <= frame_end;
      stall       <= (state == SRC_ACTIVE) && !xfer;
      if (xfer) dout <= pix_src;
    end
  end

endmodule

// File: tb/tb_filter2d_frame_src.sv
// Self-checking bench for filter2d_frame_src with a 3x4 frame; pattern test under FILTER2D_SRC_PATTERN_EN.
module tb_filter2d_frame_src;

  localparam int H    = 3;
  localparam int W    = 4;
  localparam int DW   = 8;
  localparam int MAXC = 128;
  localparam int NSRC = 64;

  logic clock = 1'b0;
  logic rst, pix_vld, start_a, start_z, pattern_sel, pattern_z;
  logic [DW-1:0] pix;
  logic busy_a, rdy_a, fs_a, dv_a, fd_a, st_a;
  logic busy_z, rdy_z, fs_z, dv_z, fd_z, st_z;
  logic [DW-1:0] dout_a, dout_z;

  always #5 clock = ~clock;

  filter2d_frame_src #(.FRAME_H(H), .FRAME_W(W), .DATA_WIDTH(DW), .HBLANK(2), .VBLANK(3)) dut (
    .clock(clock), .rst(rst), .start(start_a), .busy(busy_a), .pix_vld(pix_vld), .pix_rdy(rdy_a),
    .pix(pix),
`ifdef FILTER2D_SRC_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .frame_start(fs_a), .dout_vld(dv_a), .dout(dout_a), .frame_done(fd_a), .stall(st_a)
  );

  filter2d_frame_src #(.FRAME_H(H), .FRAME_W(W), .DATA_WIDTH(DW), .HBLANK(0), .VBLANK(0)) dut_z (
    .clock(clock), .rst(rst), .start(start_z), .busy(busy_z), .pix_vld(pix_vld), .pix_rdy(rdy_z),
    .pix(pix),
`ifdef FILTER2D_SRC_PATTERN_EN
    .pattern_sel(pattern_z),
`endif
    .frame_start(fs_z), .dout_vld(dv_z), .dout(dout_z), .frame_done(fd_z), .stall(st_z)
  );

  int total = 0;
  int bad   = 0;

  bit            st_start [MAXC];
  bit            st_vld   [MAXC];
  bit            st_rst   [MAXC];
  // Control bit order: {frame_start, dout_vld, busy, frame_done, stall, pix_rdy}
  logic [5:0]    exp_ctl  [MAXC];
  logic [5:0]    rec_ctl  [MAXC];
  logic [DW-1:0] exp_dout [MAXC];
  logic [DW-1:0] rec_dout [MAXC];
  logic [DW-1:0] src_vals [NSRC];
  int            src_head;
  int            pidx;

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      st_start[c] = 1'b0;
      st_vld[c]   = 1'b1;
      st_rst[c]   = 1'b0;
      exp_ctl[c]  = '0;
      exp_dout[c] = '0;
      rec_ctl[c]  = '0;
      rec_dout[c] = '0;
    end
    for (int i = 0; i < NSRC; i++) src_vals[i] = DW'($urandom);
    src_head = 0;
    pidx     = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_a = 1'b0; start_z = 1'b0; pix_vld = 1'b0; pix = '0;
    repeat (2) begin @(posedge clock); #1; end
    rst = 1'b0;
  endtask

  task automatic put(input int idx, input int b, input int cut);
    if (idx < cut && idx < MAXC) exp_ctl[idx][b] = 1'b1;
  endtask

  // Frame model: start seen in cycle s; outputs at or after cycle cut are suppressed by reset.
  task automatic model(input int s, input int hb, input int vb, input int cut, input bit pat,
                       output int done);
    int t;
    logic [DW-1:0] v;
    put(s + 1, 5, cut);
    t = s + 2;
    for (int r = 0; r < H; r++) begin
      for (int cc = 0; cc < W; cc++) begin
        if (!pat) begin
          while (!st_vld[t] && t < MAXC - 2) begin
            put(t, 0, cut);
            put(t + 1, 1, cut);
            t++;
          end
          put(t, 0, cut);
        end
        if (t < cut) begin
          if (pat) v = DW'(r + cc);
          else begin
            v = src_vals[pidx];
            pidx++;
          end
          if (t + 1 < cut && t + 1 < MAXC) begin
            put(t + 1, 4, cut);
            exp_dout[t + 1] = v;
          end
        end
        t++;
      end
      if (r < H - 1) t += hb;
    end
    t += vb;
    done = t;
    put(t, 2, cut);
    for (int i = s + 1; i < t; i++) put(i, 3, cut);
  endtask

  task automatic capture(input bit z, input int n);
    for (int c = 0; c < n; c++) begin
      rec_ctl[c]  = z ? {fs_z, dv_z, busy_z, fd_z, st_z, rdy_z} : {fs_a, dv_a, busy_a, fd_a, st_a, rdy_a};
      rec_dout[c] = z ? dout_z : dout_a;
      rst     = st_rst[c];
      start_a = z ? 1'b0 : st_start[c];
      start_z = z ? st_start[c] : 1'b0;
      pix_vld = st_vld[c];
      pix     = (src_head < NSRC) ? src_vals[src_head] : '0;
      if (pix_vld && (z ? rdy_z : rdy_a) && src_head < NSRC) src_head++;
      @(posedge clock); #1;
    end
    rst = 1'b0; start_a = 1'b0; start_z = 1'b0; pix_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b1; start_z = 1'b1; pix_vld = 1'b1; pix = 8'h5a;
    repeat (3) begin @(posedge clock); #1; end
    total++;
    if ({fs_a, dv_a, busy_a, fd_a, st_a, rdy_a} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl_a got=%b want=000000", {fs_a, dv_a, busy_a, fd_a, st_a, rdy_a});
    end
    total++;
    if (dout_a !== '0) begin bad++; $display("FAIL reset_dout_a got=%h want=00", dout_a); end
    total++;
    if ({fs_z, dv_z, busy_z, fd_z, st_z, rdy_z} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl_z got=%b want=000000", {fs_z, dv_z, busy_z, fd_z, st_z, rdy_z});
    end
    total++;
    if (dout_z !== '0) begin bad++; $display("FAIL reset_dout_z got=%h want=00", dout_z); end
    rst = 1'b0; start_a = 1'b0; start_z = 1'b0; pix_vld = 1'b0;
    @(posedge clock); #1;
    total++;
    if (busy_a !== 1'b0 || fs_a !== 1'b0) begin
      bad++; $display("FAIL reset_start_ignored got busy=%b fs=%b want 0 0", busy_a, fs_a);
    end
  endtask

  task automatic test_basic();
    int done, ndv;
    clear_stim(); do_reset();
    st_start[0] = 1'b1;
    model(0, 2, 3, MAXC, 1'b0, done);
    capture(1'b0, 30);
    ndv = 0;
    for (int c = 0; c < 30; c++) begin
      total++;
      if (rec_ctl[c] !== exp_ctl[c]) begin
        bad++; $display("FAIL basic_ctl cyc=%0d got=%b want=%b", c, rec_ctl[c], exp_ctl[c]);
      end
      if (exp_ctl[c][4]) begin
        total++;
        if (rec_dout[c] !== exp_dout[c]) begin
          bad++; $display("FAIL basic_dout cyc=%0d got=%h want=%h", c, rec_dout[c], exp_dout[c]);
        end
      end
      if (rec_ctl[c][4]) ndv++;
    end
    total++;
    if (ndv !== H * W) begin bad++; $display("FAIL basic_count got=%0d want=%0d", ndv, H * W); end
    total++;
    if (rec_ctl[21][2] !== 1'b1) begin bad++; $display("FAIL basic_done21 got=%b want=1", rec_ctl[21][2]); end
  endtask

  task automatic test_underrun();
    int done, nst, ndv;
    clear_stim(); do_reset();
    st_start[0] = 1'b1;
    st_vld[9] = 1'b0; st_vld[10] = 1'b0; st_vld[11] = 1'b0;
    model(0, 2, 3, MAXC, 1'b0, done);
    capture(1'b0, 32);
    nst = 0; ndv = 0;
    for (int c = 0; c < 32; c++) begin
      total++;
      if (rec_ctl[c] !== exp_ctl[c]) begin
        bad++; $display("FAIL underrun_ctl cyc=%0d got=%b want=%b", c, rec_ctl[c], exp_ctl[c]);
      end
      if (exp_ctl[c][4]) begin
        total++;
        if (rec_dout[c] !== exp_dout[c]) begin
          bad++; $display("FAIL underrun_dout cyc=%0d got=%h want=%h", c, rec_dout[c], exp_dout[c]);
        end
      end
      if (rec_ctl[c][1]) nst++;
      if (rec_ctl[c][4]) ndv++;
    end
    total++;
    if (nst !== 3) begin bad++; $display("FAIL underrun_stalls got=%0d want=3", nst); end
    total++;
    if (ndv !== H * W) begin bad++; $display("FAIL underrun_count got=%0d want=%0d", ndv, H * W); end
    total++;
    if (rec_ctl[24][2] !== 1'b1) begin bad++; $display("FAIL underrun_done24 got=%b want=1", rec_ctl[24][2]); end
  endtask

  task automatic test_random_vld();
    int done;
    clear_stim(); do_reset();
    st_start[0] = 1'b1;
    for (int c = 0; c < 60; c++) st_vld[c] = ($urandom_range(3) != 0);
    model(0, 2, 3, MAXC, 1'b0, done);
    capture(1'b0, 90);
    for (int c = 0; c < 90; c++) begin
      total++;
      if (rec_ctl[c] !== exp_ctl[c]) begin
        bad++; $display("FAIL random_ctl cyc=%0d got=%b want=%b", c, rec_ctl[c], exp_ctl[c]);
      end
      if (exp_ctl[c][4]) begin
        total++;
        if (rec_dout[c] !== exp_dout[c]) begin
          bad++; $display("FAIL random_dout cyc=%0d got=%h want=%h", c, rec_dout[c], exp_dout[c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    clear_stim(); do_reset();
    st_start[0] = 1'b1; st_start[10] = 1'b1; st_start[21] = 1'b1;
    model(0, 2, 3, MAXC, 1'b0, d1);
    model(d1, 2, 3, MAXC, 1'b0, d2);
    capture(1'b0, 50);
    for (int c = 0; c < 50; c++) begin
      total++;
      if (rec_ctl[c] !== exp_ctl[c]) begin
        bad++; $display("FAIL b2b_ctl cyc=%0d got=%b want=%b", c, rec_ctl[c], exp_ctl[c]);
      end
      if (exp_ctl[c][4]) begin
        total++;
        if (rec_dout[c] !== exp_dout[c]) begin
          bad++; $display("FAIL b2b_dout cyc=%0d got=%h want=%h", c, rec_dout[c], exp_dout[c]);
        end
      end
    end
    total++;
    if (rec_ctl[22][5] !== 1'b1) begin bad++; $display("FAIL b2b_sof22 got=%b want=1", rec_ctl[22][5]); end
  endtask

  task automatic test_reset_mid_frame();
    int d1, d2;
    clear_stim(); do_reset();
    st_start[0] = 1'b1; st_rst[9] = 1'b1; st_start[12] = 1'b1;
    model(0, 2, 3, 10, 1'b0, d1);
    model(12, 2, 3, MAXC, 1'b0, d2);
    capture(1'b0, 40);
    for (int c = 0; c < 40; c++) begin
      total++;
      if (rec_ctl[c] !== exp_ctl[c]) begin
        bad++; $display("FAIL midrst_ctl cyc=%0d got=%b want=%b", c, rec_ctl[c], exp_ctl[c]);
      end
      if (exp_ctl[c][4]) begin
        total++;
        if (rec_dout[c] !== exp_dout[c]) begin
          bad++; $display("FAIL midrst_dout cyc=%0d got=%h want=%h", c, rec_dout[c], exp_dout[c]);
        end
      end
    end
    total++;
    if (rec_dout[10] !== '0) begin bad++; $display("FAIL midrst_dout_clr got=%h want=00", rec_dout[10]); end
  endtask

  task automatic test_zero_blank();
    int done;
    clear_stim(); do_reset();
    st_start[0] = 1'b1;
    model(0, 0, 0, MAXC, 1'b0, done);
    capture(1'b1, 20);
    for (int c = 0; c < 20; c++) begin
      total++;
      if (rec_ctl[c] !== exp_ctl[c]) begin
        bad++; $display("FAIL zero_ctl cyc=%0d got=%b want=%b", c, rec_ctl[c], exp_ctl[c]);
      end
      if (exp_ctl[c][4]) begin
        total++;
        if (rec_dout[c] !== exp_dout[c]) begin
          bad++; $display("FAIL zero_dout cyc=%0d got=%h want=%h", c, rec_dout[c], exp_dout[c]);
        end
      end
    end
    total++;
    if (rec_ctl[14][2] !== 1'b1) begin bad++; $display("FAIL zero_done14 got=%b want=1", rec_ctl[14][2]); end
  endtask

`ifdef FILTER2D_SRC_PATTERN_EN
  task automatic test_pattern();
    int done;
    clear_stim(); do_reset();
    st_start[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) st_vld[c] = ($urandom_range(1) != 0);
    model(0, 2, 3, MAXC, 1'b1, done);
    pattern_sel = 1'b1;
    capture(1'b0, 30);
    pattern_sel = 1'b0;
    for (int c = 0; c < 30; c++) begin
      total++;
      if (rec_ctl[c] !== exp_ctl[c]) begin
        bad++; $display("FAIL pattern_ctl cyc=%0d got=%b want=%b", c, rec_ctl[c], exp_ctl[c]);
      end
      if (exp_ctl[c][4]) begin
        total++;
        if (rec_dout[c] !== exp_dout[c]) begin
          bad++; $display("FAIL pattern_dout cyc=%0d got=%h want=%h", c, rec_dout[c], exp_dout[c]);
        end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start_a = 1'b0; start_z = 1'b0; pix_vld = 1'b0; pix = '0;
    pattern_sel = 1'b0; pattern_z = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_basic();
    test_underrun();
    test_random_vld();
    test_back_to_back();
    test_reset_mid_frame();
    test_zero_blank();
`ifdef FILTER2D_SRC_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter2d_frame_src.md
Name: filter2d_frame_src

Overview:
Raster stream transmitter that drives the filter2d pixel input protocol (frame_start pulse, then valid-qualified pixels).
- Pulls pixels from an upstream valid/ready source, such as a frame-buffer reader or DMA.
- Frames them as FRAME_H lines of FRAME_W pixels, with programmable horizontal and vertical blanking.
- Sits directly in front of filter2d in the datapath and in benches.

Parameters:
FRAME_H, 480, lines per frame (≥1)
FRAME_W, 640, pixels per line (≥2)
DATA_WIDTH, 8, pixel width; equals the filter's DIN_WIDTH
HBLANK, 4, idle cycles between lines (≥0)
VBLANK, 16, idle cycles after the last line, before frame_done (≥0)

Ports:
clock  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to send one frame; ignored while busy
busy  out  1  high from the SOF cycle through the last VBLANK cycle
pix_vld  in  1  upstream pixel valid
pix_rdy  out  1  upstream ready; combinational, high only in ACTIVE
pix  in  DATA_WIDTH  upstream pixel
frame_start  out  1  one-cycle frame-start pulse toward the filter
dout_vld  out  1  output pixel valid
dout  out  DATA_WIDTH  output pixel
frame_done  out  1  one-cycle pulse after VBLANK completes
stall  out  1  one-cycle pulse per ACTIVE cycle with pix_vld low (upstream underrun)

Behaviour:
- Reset: state=IDLE; row, col and blank counters=0; busy, frame_start, dout_vld, frame_done, stall=0; dout=0.
- Reset mid-frame aborts immediately. No frame_done is emitted and no further dout_vld is produced.
- All outputs are registered except pix_rdy.
- FSM states: IDLE, SOF, ACTIVE, HBLK, VBLK.
- IDLE: start=1 -> SOF.
- SOF: lasts exactly 1 cycle.
  - frame_start=1 in this cycle; dout_vld=0.
  - -> ACTIVE.
- ACTIVE:
  - A transfer is pix_vld & pix_rdy; col increments per transfer.
  - No transfer leaves counters unchanged and pulses stall.
  - Transfer at col=FRAME_W-1 with row<FRAME_H-1: col=0, row++, -> HBLK (or ACTIVE if HBLANK=0).
  - Transfer at col=FRAME_W-1 with row=FRAME_H-1: -> VBLK (or DONE action directly if VBLANK=0).
- HBLK: count HBLANK cycles, then -> ACTIVE. pix_rdy=0.
- VBLK: count VBLANK cycles. On exit: frame_done=1 in the next cycle, busy=0 in that same cycle, -> IDLE.
- start is accepted in the frame_done cycle itself, giving back-to-back frames with no extra gap.
- Datapath latency: 1 cycle. dout_vld/dout register the transfer, so dout_vld is high in the cycle after each transfer.
- frame_start always precedes the first dout_vld by ≥2 cycles, and is never coincident with dout_vld.
- Pixel order: raster, row-major. Exactly FRAME_H*FRAME_W dout_vld pulses per frame.
- Counter widths: $clog2 of the respective maximum + 1. Blank counter sized for max(HBLANK,VBLANK).
- start during busy: dropped, not queued.
- start with rst high: ignored.

Optional Feature:
FILTER2D_SRC_PATTERN_EN
- With the macro: adds input port pattern_sel (1 bit, sampled on start and held for the frame).
  - When held high, pixels are generated internally: value = (row+col) truncated to DATA_WIDTH.
  - Every ACTIVE cycle is a transfer; pix_rdy=0; stall never pulses.
  - When pattern_sel is low, behaviour is identical to the macro-absent build.
- Without the macro: pattern_sel port and generator logic are absent.

Decomposition:
- filter2d_pkg additions: state enum typedef src_state_t; constants SRC_HBLANK and SRC_VBLANK. FRAME_H, FRAME_W and DIN_WIDTH are reused as parameter defaults.
- One natural sub-module: filter2d_raster_cnt.
  - Contents: col/row/blank counters.
  - Flags: last_col, last_row, blank_done.
  - FSM and output registers stay in the top.

Test Plan:
All scenarios use FRAME_H=3, FRAME_W=4, HBLANK=2, VBLANK=3, with pix_vld tied high unless noted.
- Basic frame: start at cycle 0.
  - frame_start at cycle 1; pix_rdy high cycles 2-5, 8-11, 14-17.
  - dout_vld cycles 3-6, 9-12, 15-18 with input order preserved.
  - busy cycles 1-20; frame_done at cycle 21.
- Underrun: pix_vld low for 3 cycles mid-line 1.
  - stall pulses 3 times; frame_done slips by 3 cycles.
  - Still exactly 12 dout_vld pulses in raster order.
- Back-to-back: start asserted at the frame_done cycle (21) -> frame_start at cycle 22. start at cycle 10 is ignored (no second frame).
- Reset mid-frame: rst at cycle 9.
  - Cycle 10 onward: all outputs 0, state IDLE, no frame_done.
  - A new start then produces a full correct frame.
- Zero blanking: HBLANK=0, VBLANK=0 -> pixels stream on cycles 2-13 contiguous; frame_done at cycle 14.
- Pattern (macro on, pattern_sel=1): dout sequence 0,1,2,3,1,2,3,4,2,3,4,5; pix_rdy never asserts.
